// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between two writeback requesters, each buffered by its own FIFO.
// Define WB_ARB_FIXED_PRIO_EN for fixed req0 priority; the default build arbitrates round-robin.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  input  logic [ADDR_W-1:0]    req0_rd_i,
  input  logic [DATA_W-1:0]    req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [ADDR_W-1:0]    req1_rd_i,
  input  logic [DATA_W-1:0]    req1_data_i,
  output logic                 req1_ready_o,
  output logic                 w_en_o,
  output logic [ADDR_W-1:0]    rd_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [2**ADDR_W-1:0] busy_mask_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t              mem   [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr  [2];
  logic [PTR_W-1:0] rptr  [2];
  logic [CNT_W-1:0] count [2];
  wb_t              in_ent [2];
  logic [1:0]       valid, ready, nonempty, push, pop;
  wb_t              head;
  logic [NREG-1:0]  busy;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic             last_grant;  // 1: req1 was granted most recently
`endif

  assign in_ent[0] = '{rd: req0_rd_i, data: req0_data_i};
  assign in_ent[1] = '{rd: req1_rd_i, data: req1_data_i};
  assign valid     = {req1_valid_i, req0_valid_i};
  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign busy_mask_o  = busy;

  // Handshake and arbitration from registered occupancy only
  always_comb begin
    ready    = '0;
    nonempty = '0;
    pop      = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = count[i] < CNT_W'(FIFO_DEPTH);
      nonempty[i] = count[i] != '0;
    end
    push = valid & ready;
`ifdef WB_ARB_FIXED_PRIO_EN
    pop[0] = nonempty[0];
    pop[1] = nonempty[1] && !nonempty[0];
`else
    pop[0] = nonempty[0] && (!nonempty[1] || last_grant);
    pop[1] = nonempty[1] && !pop[0];
`endif
    head = pop[1] ? mem[1][rptr[1]] : mem[0][rptr[0]];
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wptr[i]] <= in_ent[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
`ifndef WB_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      w_en_o  <= 1'b0;
      rd_o    <= '0;
      wdata_o <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (|pop) begin
`ifndef WB_ARB_FIXED_PRIO_EN
        last_grant <= pop[1];
`endif
        rd_o    <= head.rd;
        wdata_o <= head.data;
        w_en_o  <= head.rd != '0;
      end else begin
        w_en_o  <= 1'b0;
      end
    end
  end

  // Pending-write scoreboard: occupied FIFO slots plus the output stage
  always_comb begin
    busy = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (CNT_W'(PTR_W'(PTR_W'(j) - rptr[i])) < count[i]) busy[mem[i][j].rd] = 1'b1;
      end
    end
    if (w_en_o) busy[rd_o] = 1'b1;
    busy[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: queue-level model predicts writes, a monitor checks them.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic [4:0]  req0_rd_i = '0, req1_rd_i = '0;
  logic [31:0] req0_data_i = '0, req1_data_i = '0;
  logic        req0_ready_o, req1_ready_o, w_en_o;
  logic [4:0]  rd_o;
  logic [31:0] wdata_o;
  logic [31:0] busy_mask_o;

  regfile_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_rd_i(req0_rd_i), .req0_data_i(req0_data_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_rd_i(req1_rd_i), .req1_data_i(req1_data_i),
    .req1_ready_o(req1_ready_o),
    .w_en_o(w_en_o), .rd_o(rd_o), .wdata_o(wdata_o), .busy_mask_o(busy_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; logic [31:0] data; } ent_t;
  typedef struct { int cyc; int rd; logic [31:0] data; } exp_t;

  ent_t q0[$], q1[$];
  exp_t expq[$];
  bit   lg = 1'b1;          // requester granted last time
  bit   out_en = 1'b0;
  int   out_rd = 0;
  int   cycle = 0;
  int   n_cmp = 0, n_bad = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    foreach (q0[i]) m[q0[i].rd] = 1'b1;
    foreach (q1[i]) m[q1[i].rd] = 1'b1;
    if (out_en) m[out_rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock: check visible state, advance the model for the next edge, drive inputs
  task automatic do_cycle(input bit v0, input int r0, input logic [31:0] d0,
                          input bit v1, input int r1, input logic [31:0] d1);
    bit a0, a1, ne0, ne1, p0, p1;
    ent_t e;
    @(negedge clk);
    chk("req0_ready", 64'(req0_ready_o), 64'(q0.size() < DEPTH));
    chk("req1_ready", 64'(req1_ready_o), 64'(q1.size() < DEPTH));
    chk("busy_mask", 64'(busy_mask_o), 64'(model_busy()));
    a0 = v0 && (q0.size() < DEPTH);
    a1 = v1 && (q1.size() < DEPTH);
    ne0 = q0.size() != 0;
    ne1 = q1.size() != 0;
`ifdef WB_ARB_FIXED_PRIO_EN
    p0 = ne0;
    p1 = ne1 && !ne0;
`else
    p0 = ne0 && (!ne1 || lg);
    p1 = ne1 && !p0;
`endif
    if (p0) begin e = q0.pop_front(); lg = 1'b0; end
    else if (p1) begin e = q1.pop_front(); lg = 1'b1; end
    if (p0 || p1) begin
      out_en = e.rd != 0;
      out_rd = e.rd;
      if (out_en) expq.push_back('{cyc: cycle + 1, rd: e.rd, data: e.data});
    end else begin
      out_en = 1'b0;
    end
    if (a0) q0.push_back('{rd: r0, data: d0});
    if (a1) q1.push_back('{rd: r1, data: d1});
    req0_valid_i = v0; req0_rd_i = 5'(r0); req0_data_i = d0;
    req1_valid_i = v1; req1_rd_i = 5'(r1); req1_data_i = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, '0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    #1;
    chk("rst_w_en", 64'(w_en_o), 64'(0));
    chk("rst_rd", 64'(rd_o), 64'(0));
    chk("rst_wdata", 64'(wdata_o), 64'(0));
    chk("rst_busy", 64'(busy_mask_o), 64'(0));
    q0.delete(); q1.delete(); expq.delete();
    lg = 1'b1; out_en = 1'b0; out_rd = 0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Monitor: every write the DUT presents must match the next predicted write and its cycle
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i && w_en_o) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                   rd_o, wdata_o, cycle);
        end else begin
          x = expq.pop_front();
          chk("write_cycle", 64'(cycle), 64'(x.cyc));
          chk("write_rd", 64'(rd_o), 64'(x.rd));
          chk("write_data", 64'(wdata_o), 64'(x.data));
        end
      end
    end
  end

  initial begin
    do_reset();
    // single write to x5
    do_cycle(1, 5, 32'hDEADBEEF, 0, 0, '0);
    idle(4);
    // write to x0 is consumed silently
    do_cycle(1, 0, 32'h1234, 0, 0, '0);
    idle(3);
    // contention: four writes from each side back to back
    for (int i = 0; i < 4; i++)
      do_cycle(1, 1 + i, 32'hA000_0000 + 32'(i), 1, 11 + i, 32'hB000_0000 + 32'(i));
    idle(10);
    // same destination from both requesters
    do_cycle(1, 7, 32'h7777_0000, 1, 7, 32'h7777_0001);
    do_cycle(1, 7, 32'h7777_0002, 0, 0, '0);
    idle(6);
    // back-pressure: req1 held valid while req0 streams
    for (int i = 0; i < 8; i++)
      do_cycle(1, 20 + (i % 4), $urandom, 1, 24 + (i % 4), $urandom);
    idle(8);
    // randomized traffic with small rd range to exercise hazards and x0
    for (int i = 0; i < 400; i++)
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9), $urandom,
               $urandom_range(0, 2) != 0, $urandom_range(0, 9), $urandom);
    // fill both FIFOs, then reset mid-stream
    for (int i = 0; i < 5; i++)
      do_cycle(1, $urandom_range(1, 31), $urandom, 1, $urandom_range(1, 31), $urandom);
    do_reset();
    do_cycle(1, 9, 32'hCAFE_F00D, 1, 10, 32'hBEEF_CAFE);
    idle(8);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d outstanding expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
